// File: rtl/stall_ctrl.sv
// stall_ctrl: merges load-use, divide and memory-wait stall requests into the pipeline stall bus
//   clk            : clock, all state on rising edge
//   rst            : asynchronous active-low reset
//   stall_for_load : load-use hazard from the forwarding unit
//   ex_div_req     : EX holds a divide needing the divider
//   div_ready      : divider result valid pulse
//   mem_wait       : data SRAM not ready
//   flush          : exception/eret flush, highest priority
//   stall          : [0]PC [1]IF [2]ID [3]EX [4]MEM [5]WB, 1 = stop
//   div_start      : one-cycle divider launch pulse
//   div_cancel     : one-cycle divider abort pulse
//   div_busy       : divide launched and not yet resolved
//   div_timeout    : sticky divider timeout flag
//   stall_cycles   : saturating count of cycles with the PC stalled
module stall_ctrl #(
    parameter int DIV_TIMEOUT = 64,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_for_load,
    input  logic             ex_div_req,
    input  logic             div_ready,
    input  logic             mem_wait,
    input  logic             flush,
    output logic [5:0]       stall,
    output logic             div_start,
    output logic             div_cancel,
    output logic             div_busy,
    output logic             div_timeout,
    output logic [CNT_W-1:0] stall_cycles
);
    localparam int WC_W = $clog2(DIV_TIMEOUT);
    localparam logic [WC_W-1:0] WC_MAX = WC_W'(DIV_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, DIV_START, DIV_WAIT, DIV_DONE} state_t;

    state_t          state, state_nxt;
    logic [WC_W-1:0] wait_cnt, wait_cnt_nxt;
    logic            timeout_nxt;

    assign div_start = state == DIV_START;
    assign div_busy  = state == DIV_START || state == DIV_WAIT;

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        timeout_nxt  = div_timeout;
        case (state)
            IDLE:      state_nxt = ex_div_req && !flush && !mem_wait ? DIV_START : IDLE;
            DIV_START: begin
                state_nxt    = DIV_WAIT;
                wait_cnt_nxt = '0;
            end
            DIV_WAIT:  begin
                if (div_ready) state_nxt = DIV_DONE;
                // counter parks at the limit so the flag is raised once and held
                else if (wait_cnt == WC_MAX) timeout_nxt = 1'b1;
                else wait_cnt_nxt = wait_cnt + 1'b1;
            end
            default:   state_nxt = IDLE;
        endcase
        if (flush) state_nxt = IDLE;
    end

    // combinational outputs are masked during reset so input activity cannot leak out
    always_comb begin
        div_cancel = rst && flush && div_busy;
        stall = !rst || flush ? 6'b000000 :
                mem_wait ? 6'b011111 :
                (ex_div_req && state != DIV_DONE) || div_busy ? 6'b001111 :
                stall_for_load ? 6'b000111 : 6'b000000;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            wait_cnt     <= '0;
            div_timeout  <= 1'b0;
            stall_cycles <= '0;
        end else begin
            state       <= state_nxt;
            wait_cnt    <= wait_cnt_nxt;
            div_timeout <= timeout_nxt;
            if (stall[0] && stall_cycles != '1) stall_cycles <= stall_cycles + 1'b1;
        end
    end
endmodule

// File: tb/tb_stall_ctrl.sv
// tb_stall_ctrl: directed self-checking bench for stall_ctrl
module tb_stall_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       stall_for_load = 1'b0;
    logic       ex_div_req = 1'b0;
    logic       div_ready = 1'b0;
    logic       mem_wait = 1'b0;
    logic       flush = 1'b0;
    logic [5:0] stall;
    logic       div_start;
    logic       div_cancel;
    logic       div_busy;
    logic       div_timeout;
    logic [3:0] stall_cycles;
    int         nc = 0;
    int         nf = 0;

    stall_ctrl #(.DIV_TIMEOUT(8), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .stall_for_load(stall_for_load), .ex_div_req(ex_div_req),
        .div_ready(div_ready), .mem_wait(mem_wait), .flush(flush), .stall(stall),
        .div_start(div_start), .div_cancel(div_cancel), .div_busy(div_busy),
        .div_timeout(div_timeout), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        repeat (2) @(negedge clk);
        #1;
        nc++; if (stall !== 6'b000000) begin nf++; $display("FAIL reset_stall: got %b want 000000", stall); end
        nc++; if (div_busy !== 1'b0 || div_start !== 1'b0 || div_timeout !== 1'b0) begin nf++; $display("FAIL reset_flags: got busy=%b start=%b to=%b want 0", div_busy, div_start, div_timeout); end
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            nc++; if (stall !== 6'b000000) begin nf++; $display("FAIL idle_stall[%0d]: got %b want 000000", i, stall); end
        end
        nc++; if (stall_cycles !== 4'd0 || div_busy !== 1'b0) begin nf++; $display("FAIL idle_cnt: got cnt=%0d busy=%b want 0/0", stall_cycles, div_busy); end
    endtask

    task automatic test_load();
        @(negedge clk);
        stall_for_load = 1'b1;
        #1;
        nc++; if (stall !== 6'b000111) begin nf++; $display("FAIL load_stall: got %b want 000111", stall); end
        @(negedge clk);
        stall_for_load = 1'b0;
        #1;
        nc++; if (stall !== 6'b000000) begin nf++; $display("FAIL load_release: got %b want 000000", stall); end
        nc++; if (stall_cycles !== 4'd1) begin nf++; $display("FAIL load_cnt: got %0d want 1", stall_cycles); end
    endtask

    task automatic test_divide();
        @(negedge clk);
        ex_div_req = 1'b1;
        #1;
        nc++; if (stall !== 6'b001111 || div_start !== 1'b0) begin nf++; $display("FAIL div_req: got stall=%b start=%b want 001111/0", stall, div_start); end
        @(negedge clk);
        #1;
        nc++; if (div_start !== 1'b1 || div_busy !== 1'b1 || stall !== 6'b001111) begin nf++; $display("FAIL div_start: got start=%b busy=%b stall=%b want 1/1/001111", div_start, div_busy, stall); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            div_ready = i == 4;
            #1;
            nc++; if (stall !== 6'b001111 || div_start !== 1'b0) begin nf++; $display("FAIL div_wait[%0d]: got stall=%b start=%b want 001111/0", i, stall, div_start); end
        end
        @(negedge clk);
        div_ready = 1'b0;
        #1;
        nc++; if (stall !== 6'b000000 || div_busy !== 1'b0) begin nf++; $display("FAIL div_done: got stall=%b busy=%b want 000000/0", stall, div_busy); end
        @(negedge clk);
        ex_div_req = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            nc++; if (div_start !== 1'b0 || stall !== 6'b000000) begin nf++; $display("FAIL div_no_restart[%0d]: got start=%b stall=%b want 0/000000", i, div_start, stall); end
            @(negedge clk);
        end
        #1;
        nc++; if (stall_cycles !== 4'd8) begin nf++; $display("FAIL div_cnt: got %0d want 8", stall_cycles); end
    endtask

    task automatic test_flush();
        @(negedge clk);
        ex_div_req = 1'b1;
        repeat (3) @(negedge clk);
        flush = 1'b1;
        ex_div_req = 1'b0;
        #1;
        nc++; if (stall !== 6'b000000 || div_cancel !== 1'b1) begin nf++; $display("FAIL flush_wait: got stall=%b cancel=%b want 000000/1", stall, div_cancel); end
        @(negedge clk);
        flush = 1'b0;
        #1;
        nc++; if (div_busy !== 1'b0 || div_cancel !== 1'b0) begin nf++; $display("FAIL flush_idle: got busy=%b cancel=%b want 0/0", div_busy, div_cancel); end
        @(negedge clk);
        div_ready = 1'b1;
        @(negedge clk);
        div_ready = 1'b0;
        ex_div_req = 1'b1;
        #1;
        nc++; if (stall !== 6'b001111) begin nf++; $display("FAIL ready_ignored: got %b want 001111", stall); end
        @(negedge clk);
        #1;
        nc++; if (div_start !== 1'b1) begin nf++; $display("FAIL restart: got start=%b want 1", div_start); end
        flush = 1'b1;
        ex_div_req = 1'b0;
        #1;
        nc++; if (div_cancel !== 1'b1 || stall !== 6'b000000) begin nf++; $display("FAIL flush_start: got cancel=%b stall=%b want 1/000000", div_cancel, stall); end
        @(negedge clk);
        flush = 1'b0;
        #1;
        nc++; if (div_busy !== 1'b0 || stall_cycles !== 4'd12) begin nf++; $display("FAIL flush_cnt: got busy=%b cnt=%0d want 0/12", div_busy, stall_cycles); end
    endtask

    task automatic test_timeout();
        @(negedge clk);
        ex_div_req = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            #1;
            nc++; if (div_timeout !== 1'b0) begin nf++; $display("FAIL timeout_early[%0d]: got %b want 0", i, div_timeout); end
        end
        @(negedge clk);
        #1;
        nc++; if (div_timeout !== 1'b1 || div_busy !== 1'b1) begin nf++; $display("FAIL timeout_set: got to=%b busy=%b want 1/1", div_timeout, div_busy); end
        nc++; if (stall_cycles !== 4'd15) begin nf++; $display("FAIL cnt_saturate: got %0d want 15", stall_cycles); end
        @(negedge clk);
        flush = 1'b1;
        ex_div_req = 1'b0;
        #1;
        nc++; if (div_cancel !== 1'b1) begin nf++; $display("FAIL timeout_cancel: got %b want 1", div_cancel); end
        @(negedge clk);
        flush = 1'b0;
        #1;
        nc++; if (div_timeout !== 1'b1 || div_busy !== 1'b0 || stall_cycles !== 4'd15) begin nf++; $display("FAIL timeout_sticky: got to=%b busy=%b cnt=%0d want 1/0/15", div_timeout, div_busy, stall_cycles); end
    endtask

    task automatic test_combo();
        @(negedge clk);
        mem_wait = 1'b1;
        stall_for_load = 1'b1;
        ex_div_req = 1'b1;
        #1;
        nc++; if (stall !== 6'b011111) begin nf++; $display("FAIL combo_mem: got %b want 011111", stall); end
        @(negedge clk);
        #1;
        nc++; if (stall !== 6'b011111 || div_start !== 1'b0) begin nf++; $display("FAIL combo_defer: got stall=%b start=%b want 011111/0", stall, div_start); end
        @(negedge clk);
        mem_wait = 1'b0;
        #1;
        nc++; if (stall !== 6'b001111 || div_start !== 1'b0) begin nf++; $display("FAIL combo_div: got stall=%b start=%b want 001111/0", stall, div_start); end
        @(negedge clk);
        #1;
        nc++; if (div_start !== 1'b1) begin nf++; $display("FAIL combo_start: got %b want 1", div_start); end
        @(negedge clk);
        mem_wait = 1'b1;
        #1;
        nc++; if (div_busy !== 1'b1 || stall !== 6'b011111) begin nf++; $display("FAIL combo_wait: got busy=%b stall=%b want 1/011111", div_busy, stall); end
        #1;
        rst = 1'b0;
        #1;
        nc++; if (stall !== 6'b000000 || div_busy !== 1'b0 || div_start !== 1'b0 || div_cancel !== 1'b0) begin nf++; $display("FAIL async_rst: got stall=%b busy=%b start=%b cancel=%b want 0", stall, div_busy, div_start, div_cancel); end
        nc++; if (div_timeout !== 1'b0 || stall_cycles !== 4'd0) begin nf++; $display("FAIL async_rst_regs: got to=%b cnt=%0d want 0/0", div_timeout, stall_cycles); end
        mem_wait = 1'b0;
        stall_for_load = 1'b0;
        ex_div_req = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_load();
        test_divide();
        test_flush();
        test_timeout();
        test_combo();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nc, nf);
        $finish;
    end
endmodule
